ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
//  Consumes the operands and M-extension op that ID/EX presents, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU,
//  and drives BUSY into the pipeline-register BUSYWAIT stall network until the result is ready.
//  EX result mux selects RESULT when DONE=1.
// PARAMETERS
//  XLEN        32   operand/result width
//  CNT_W       6    iteration counter width; must hold XLEN
// PORTS
//  CLK       in   1     clock; all state updates on posedge
//  RESET     in   1     synchronous, active-high reset
//  START     in   1     ID/EX holds a valid M-extension op this cycle
//  OP        in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  DATA1     in   XLEN  rs1 operand (post-forwarding)
//  DATA2     in   XLEN  rs2 operand (post-forwarding)
//  RESULT    out  XLEN  result; valid only while DONE=1
//  DONE      out  1     one-cycle result-valid strobe
//  BUSY      out  1     stall request to PC/IF-ID/ID-EX/EX-MEM BUSYWAIT
// BEHAVIOUR
//  Reset: posedge with RESET=1 -> state IDLE, counter 0, RESULT=0, DONE=0, internal regs 0.
//   BUSY=0 while RESET=1. Reset mid-operation aborts with no DONE pulse.
//  States and transitions:
//   IDLE -> MUL on START & OP[2]=0.
//   IDLE -> DIV on START & OP[2]=1 & normal operands.
//   IDLE -> DONE on START & special divide case.
//   MUL/DIV -> DONE after XLEN iterations.
//   DONE -> IDLE unconditionally.
//  BUSY = (state==IDLE & START & !RESET) | state==MUL | state==DIV. It is combinational so ID/EX freezes in the START cycle.
//  BUSY=0 in DONE, so the pipeline advances at the edge that ends DONE, and START deasserts or shows the next op.
//  Operand capture on the START edge:
//   Signedness per OP: MULH both signed; MULHSU rs1 signed, rs2 unsigned; DIV/REM signed; others unsigned.
//   Magnitudes are stored; result sign is latched.
//  MUL: shift-add over 2*XLEN product, 1 bit per cycle, XLEN cycles.
//   Two's-complement negate of full product if sign set.
//   MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
//  DIV: restoring shift-subtract, 1 quotient bit per cycle, XLEN cycles.
//   Quotient sign = sign1^sign2; remainder sign = sign of dividend.
//  Special cases, resolved at capture with no iteration (DONE on next cycle):
//   divisor 0: DIV/DIVU -> all ones; REM/REMU -> DATA1.
//   signed overflow (DATA1=0x80000000, DATA2=-1, DIV/REM): DIV -> 0x80000000; REM -> 0.
//  Latency: normal op DONE in cycle XLEN+1 after START edge (33 for XLEN=32); special case DONE in cycle 1.
//  START while in MUL/DIV/DONE: ignored. Operands are not re-sampled mid-operation.
//  RESULT holds its last value after DONE. Consumers sample it only while DONE=1.
//  Counter: counts 0..XLEN-1 and never wraps; the transition to DONE fires at count==XLEN-1.
// TESTING
//  MUL 7*-3 (DATA1=7, DATA2=0xFFFFFFFD, OP=0) -> BUSY 33 cycles, DONE with RESULT=0xFFFFFFEB.
//  MULH 0x80000000*0x80000000 -> RESULT=0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU -1*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  DIVU 5/0 -> RESULT=0xFFFFFFFF, REM 5/0 -> 5, both DONE one cycle after START.
//   DIV 0x80000000/-1 -> 0x80000000 with 1-cycle latency.
//  Assert RESET at iteration 10 of a DIV -> next cycle BUSY=0, DONE=0, state IDLE.
//   A fresh MUL 3*4 then returns 12 after 33 cycles.
//  Back-to-back: hold START high across DONE with a new op -> second op captured only after the return to IDLE.
//   Exactly one DONE per op; no op is lost or duplicated.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: ID/EX to EX multiply/divide handshake.
// Ports: START/OP/DATA1/DATA2 issue an RV32M op; RESULT/DONE return it; BUSY stalls the pipeline.
// master = pipeline side, slave = muldiv unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            START;
    logic [2:0]      OP;
    logic [XLEN-1:0] DATA1;
    logic [XLEN-1:0] DATA2;
    logic [XLEN-1:0] RESULT;
    logic            DONE;
    logic            BUSY;
    modport master (output START, OP, DATA1, DATA2, input RESULT, DONE, BUSY);
    modport slave  (input START, OP, DATA1, DATA2, output RESULT, DONE, BUSY);
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit, one bit per cycle.
// Ports: CLK, RESET (sync, active-high), bus (slave): START/OP/DATA1/DATA2 in, RESULT/DONE/BUSY out.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic             CLK,
    input logic             RESET,
    ex_muldiv_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d, result_q, result_d;
    logic [1:0]        op_q, op_d;
    logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic              sgn_a, sgn_b, neg_a, neg_b, div0, ovf;
    logic [XLEN-1:0]   mag_a, mag_b, quo, rem;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, mul_full;
    assign sgn_a = bus.OP inside {3'd1, 3'd2, 3'd4, 3'd6};
    assign sgn_b = bus.OP inside {3'd1, 3'd4, 3'd6};
    assign neg_a = sgn_a & bus.DATA1[XLEN-1];
    assign neg_b = sgn_b & bus.DATA2[XLEN-1];
    assign mag_a = neg_a ? -bus.DATA1 : bus.DATA1;
    assign mag_b = neg_b ? -bus.DATA2 : bus.DATA2;
    assign div0  = bus.DATA2 == '0;
    assign ovf   = sgn_b & (bus.DATA1 == MIN_NEG) & (&bus.DATA2);
    // acc holds {partial product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opb_q};
    // borrow out of the subtract means restore the shifted remainder and shift in a 0 quotient bit
    assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign mul_full = (neg_a_q ^ neg_b_q) ? -mul_next : mul_next;
    assign quo      = (neg_a_q ^ neg_b_q) ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    assign rem      = neg_a_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    // combinational so ID/EX freezes in the START cycle itself
    assign bus.BUSY   = ~RESET & (((state_q == S_IDLE) & bus.START) | (state_q == S_MUL) | (state_q == S_DIV));
    assign bus.DONE   = state_q == S_DONE;
    assign bus.RESULT = result_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        if (state_q == S_IDLE && bus.START) begin
            op_d    = bus.OP[1:0];
            neg_a_d = neg_a;
            neg_b_d = neg_b;
            opb_d   = mag_b;
            acc_d   = {{XLEN{1'b0}}, mag_a};
            cnt_d   = '0;
            state_d = !bus.OP[2] ? S_MUL : (div0 | ovf) ? S_DONE : S_DIV;
            if (bus.OP[2] && (div0 || ovf))
                result_d = bus.OP[1] ? (div0 ? bus.DATA1 : '0) : (div0 ? '1 : MIN_NEG);
        end else if (state_q == S_MUL || state_q == S_DIV) begin
            acc_d = (state_q == S_MUL) ? mul_next : div_next;
            if (cnt_q == LAST) begin
                state_d  = S_DONE;
                result_d = (state_q == S_MUL) ? ((op_q == 2'd0) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN])
                                              : (op_q[1] ? rem : quo);
            end else
                cnt_d = cnt_q + 1'b1;
        end else if (state_q == S_DONE)
            state_d = S_IDLE;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: self-checking bench for ex_muldiv_unit with directed and random ops against an arithmetic model.
module tb_ex_muldiv_unit;
    logic CLK = 1'b0;
    logic RESET;
    int errors = 0;
    int checks = 0;
    ex_muldiv_unit_if #(.XLEN(32)) bus ();
    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
    always #5 CLK = ~CLK;

    localparam logic [2:0]  D_OP [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4};
    localparam logic [31:0] D_A  [11] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEC, 32'hFFFFFFEC,
                                          32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000};
    localparam logic [31:0] D_B  [11] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'd3,
                                          32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF};
    localparam logic [31:0] D_E  [11] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA,
                                          32'hFFFFFFFE, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000};
    localparam int          D_L  [11] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1};

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ss, su, uu;
        logic ovf;
        ss  = 64'($signed(a)) * 64'($signed(b));
        su  = 64'($signed(a)) * {32'b0, b};
        uu  = {32'b0, a} * {32'b0, b};
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (op)
            3'd0: return uu[31:0];
            3'd1: return ss[63:32];
            3'd2: return su[63:32];
            3'd3: return uu[63:32];
            3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // called at a negedge with START low; returns at the negedge after the DONE cycle
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n, output logic [31:0] res, output logic done_after);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.DATA1 = a;
        bus.DATA2 = b;
        #1 busy_n = int'(bus.BUSY);
        @(posedge CLK);
        #1 bus.START = 1'b0;
        lat = 0;
        res = 'x;
        while (lat < 100) begin
            @(negedge CLK);
            lat++;
            if (bus.DONE) begin
                res = bus.RESULT;
                break;
            end
            busy_n += int'(bus.BUSY);
        end
        @(negedge CLK);
        done_after = bus.DONE;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.START = 1'b1;
        bus.OP = 3'd0;
        bus.DATA1 = 32'd5;
        bus.DATA2 = 32'd3;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.DONE); end
        checks++; if (bus.RESULT !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.RESULT); end
        bus.START = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.BUSY); end
        bus.START = 1'b1;
        #1;
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL idle_start_busy: got %b want 1", bus.BUSY); end
        bus.START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_directed();
        int lat, busy_n;
        logic [31:0] res;
        logic da;
        for (int i = 0; i < 11; i++) begin
            do_op(D_OP[i], D_A[i], D_B[i], lat, busy_n, res, da);
            checks++; if (res !== D_E[i]) begin errors++; $display("FAIL dir_result[%0d]: got %h want %h", i, res, D_E[i]); end
            checks++; if (lat != D_L[i]) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, D_L[i]); end
            checks++; if (busy_n != D_L[i]) begin errors++; $display("FAIL dir_busy_cycles[%0d]: got %0d want %0d", i, busy_n, D_L[i]); end
            checks++; if (da !== 1'b0) begin errors++; $display("FAIL dir_done_one_cycle[%0d]: got %b want 0", i, da); end
        end
    endtask

    task automatic test_random();
        int lat, busy_n;
        logic [31:0] res, a, b, e;
        logic [2:0] op;
        logic da;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            e  = model(op, a, b);
            do_op(op, a, b, lat, busy_n, res, da);
            checks++; if (res !== e) begin errors++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, e); end
            checks++; if (lat != exp_lat(op, a, b)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, exp_lat(op, a, b)); end
            checks++; if (busy_n != exp_lat(op, a, b)) begin errors++; $display("FAIL rnd_busy_cycles[%0d]: got %0d want %0d", i, busy_n, exp_lat(op, a, b)); end
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, busy_n, dn;
        logic [31:0] res;
        logic da;
        bus.START = 1'b1;
        bus.OP    = 3'd4;
        bus.DATA1 = 32'd1000;
        bus.DATA2 = 32'd7;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        repeat (10) @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy_in_reset: got %b want 0", bus.BUSY); end
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b want 0", bus.DONE); end
        dn = 0;
        repeat (40) begin
            @(negedge CLK);
            dn += int'(bus.DONE);
        end
        checks++; if (dn != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", dn); end
        do_op(3'd0, 32'd3, 32'd4, lat, busy_n, res, da);
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL rst_mid_fresh_mul: got %h want %h", res, 32'd12); end
        checks++; if (lat != 33) begin errors++; $display("FAIL rst_mid_fresh_latency: got %0d want 33", lat); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            logic [2:0] o1, o2;
            logic [31:0] a1, b1, a2, b2;
            int n, dn;
            o1 = 3'($urandom_range(0, 7));
            o2 = 3'($urandom_range(0, 7));
            a1 = pick(); b1 = pick(); a2 = pick(); b2 = pick();
            bus.START = 1'b1;
            bus.OP = o1; bus.DATA1 = a1; bus.DATA2 = b1;
            @(posedge CLK);
            // next op presented immediately; must not disturb the running one
            #1 bus.OP = o2; bus.DATA1 = a2; bus.DATA2 = b2;
            n = 0;
            while (n < 100) begin
                @(negedge CLK);
                n++;
                if (bus.DONE) break;
            end
            checks++; if (n != exp_lat(o1, a1, b1)) begin errors++; $display("FAIL b2b_first_latency[%0d]: got %0d want %0d", r, n, exp_lat(o1, a1, b1)); end
            checks++; if (bus.RESULT !== model(o1, a1, b1)) begin errors++; $display("FAIL b2b_first_result[%0d]: got %h want %h", r, bus.RESULT, model(o1, a1, b1)); end
            @(negedge CLK);
            checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL b2b_idle_done[%0d]: got %b want 0", r, bus.DONE); end
            checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL b2b_idle_busy[%0d]: got %b want 1", r, bus.BUSY); end
            @(posedge CLK);
            #1 bus.START = 1'b0;
            n = 0;
            while (n < 100) begin
                @(negedge CLK);
                n++;
                if (bus.DONE) break;
            end
            checks++; if (n != exp_lat(o2, a2, b2)) begin errors++; $display("FAIL b2b_second_latency[%0d]: got %0d want %0d", r, n, exp_lat(o2, a2, b2)); end
            checks++; if (bus.RESULT !== model(o2, a2, b2)) begin errors++; $display("FAIL b2b_second_result[%0d]: got %h want %h", r, bus.RESULT, model(o2, a2, b2)); end
            dn = 0;
            repeat (40) begin
                @(negedge CLK);
                dn += int'(bus.DONE);
            end
            checks++; if (dn != 0) begin errors++; $display("FAIL b2b_extra_done[%0d]: got %0d pulses want 0", r, dn); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
